barrett_param_gen: RTL and testbench

BARRETT_PARAM_GEN -- requirements
Module: barrett_param_gen

---
 rtl/barrett_param_gen.sv | 164 ++++++++++++++++
 tb/tb_barrett_param_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/barrett_param_gen.sv
// barrett_param_gen: produces the Barrett reduction pair (mu, k) for a modulus q.
//   k  = bit length of q (index of the most significant set bit plus 1)
//   mu = floor(2^(2k) / q), computed by restoring division, one quotient bit per cycle
// Valid moduli are 1 .. 2^29-1. Any other q returns err=1 with mu=0 and k=0.
//
// Optional feature: define BARRETT_PARAM_EARLY_EXIT_EN to start the division at
// dividend bit 2k instead of bit 58. Latency becomes 2k+3 cycles. Results are
// identical in both builds.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; ready=1
//   NORM   | leading-one detect on the latched q, range check
//   DIV    | restoring division of 2^(2k) by q, MSB first
//   DONE   | one-cycle done strobe; mu/k/err were loaded on entry
module barrett_param_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] q,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [30:0] mu,
    output logic [7:0]  k
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] q_lat_q, q_lat_d;
    logic [29:0] rem_q, rem_d;
    logic [30:0] quo_q, quo_d;
    logic [5:0]  idx_q, idx_d;
    logic [4:0]  kw_q, kw_d;
    logic [30:0] mu_q, mu_d;
    logic [7:0]  k_q, k_d;
    logic        err_q, err_d;

    logic [4:0]  lod;
    logic        q_bad;
    logic        dbit;
    logic [30:0] rem_sh;
    logic [30:0] q_ext;
    logic        ge;
    logic [29:0] rem_next;
    logic [30:0] quo_next;

    // Leading-one detector over the in-range bits of the latched modulus.
    always_comb begin
        lod = '0;
        for (int i = 0; i < 29; i++) begin
            if (q_lat_q[i]) lod = 5'(i + 1);
        end
    end

    // Out of range: zero, or any bit at or above 2^29 set.
    assign q_bad = (q_lat_q[28:0] == 29'd0) || (|q_lat_q[63:29]);

    // One restoring-division step. The dividend 2^(2k) has a single set bit at 2k.
    // The shifted remainder is kept one bit wider so the compare never overflows.
    always_comb begin
        dbit     = (idx_q == {kw_q, 1'b0});
        rem_sh   = {rem_q, dbit};
        q_ext    = {2'b00, q_lat_q[28:0]};
        ge       = (rem_sh >= q_ext);
        rem_next = ge ? 30'(rem_sh - q_ext) : 30'(rem_sh);
        quo_next = 31'({quo_q, ge});
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        q_lat_d = q_lat_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        idx_d   = idx_q;
        kw_d    = kw_q;
        mu_d    = mu_q;
        k_d     = k_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_lat_d = q;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                rem_d = '0;
                quo_d = '0;
                if (q_bad) begin
                    err_d   = 1'b1;
                    mu_d    = '0;
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    kw_d    = lod;
`ifdef BARRETT_PARAM_EARLY_EXIT_EN
                    idx_d   = {lod, 1'b0};
`else
                    idx_d   = 6'd58;
`endif
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                quo_d = quo_next;
                idx_d = idx_q - 6'd1;
                if (idx_q == 6'd0) begin
                    mu_d    = quo_next;
                    k_d     = {3'b000, kw_q};
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_lat_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            idx_q   <= '0;
            kw_q    <= '0;
            mu_q    <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_lat_q <= q_lat_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            idx_q   <= idx_d;
            kw_q    <= kw_d;
            mu_q    <= mu_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;
    assign mu    = mu_q;
    assign k     = k_q;

endmodule

// File: tb/tb_barrett_param_gen.sv
// Self-checking bench for barrett_param_gen: scoreboard of expected (mu, k, err, latency)
// pushed when a start is accepted and popped when done is observed.
module tb_barrett_param_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] q;
    logic        ready;
    logic        done;
    logic        err;
    logic [30:0] mu;
    logic [7:0]  k;

    typedef struct {
        logic [63:0] mu;
        logic [63:0] k;
        logic [63:0] err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    barrett_param_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .q     (q),
        .ready (ready),
        .done  (done),
        .err   (err),
        .mu    (mu),
        .k     (k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: arithmetic division of 2^(2k) by q.
    task automatic push_exp(input logic [63:0] qv);
        exp_t e;
        int   kk;
        kk = 0;
        for (int i = 0; i < 64; i++) if (qv[i]) kk = i + 1;
        if (qv == 64'd0 || qv >= 64'd536870912) begin
            e.mu = 0; e.k = 0; e.err = 1; e.cyc = 2;
        end else begin
            e.mu  = (64'd1 << (2 * kk)) / qv;
            e.k   = 64'(kk);
            e.err = 0;
`ifdef BARRETT_PARAM_EARLY_EXIT_EN
            e.cyc = 2 * kk + 3;
`else
            e.cyc = 61;
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start for one edge; afterwards we are in cycle 1 and q is scrambled.
    task automatic launch(input logic [63:0] qv);
        @(negedge clk);
        q     = qv;
        start = 1'b1;
        push_exp(qv);
        @(posedge clk);
        #1;
        cyc   = 1;
        start = 1'b0;
        q     = 64'h0000_0000_0000_0003;
        chk("accept_ready_low", {63'd0, ready}, 64'd0);
    endtask

    task automatic wait_done(input string tag, input bit post);
        exp_t e;
        while (!done && cyc < 200) step();
        chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            if (done) begin
                chk({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({tag, "_mu"},  {33'd0, mu}, e.mu);
                chk({tag, "_k"},   {56'd0, k},  e.k);
                chk({tag, "_err"}, {63'd0, err}, e.err);
            end
        end
        if (post) begin
            step();
            chk({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
            chk({tag, "_ready_after"}, {63'd0, ready}, 64'd1);
            chk({tag, "_mu_held"}, {33'd0, mu}, e.mu);
        end
    endtask

    task automatic run(input string tag, input logic [63:0] qv);
        launch(qv);
        wait_done(tag, 1'b1);
    endtask

    initial begin
        start = 1'b0;
        q     = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done",  {63'd0, done},  64'd0);
        chk("rst_err",   {63'd0, err},   64'd0);
        chk("rst_mu",    {33'd0, mu},    64'd0);
        chk("rst_k",     {56'd0, k},     64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("q13",    64'd13);
        run("q12289", 64'd12289);
        run("q1",     64'd1);
        run("q2p28",  64'd268435456);
        run("q2p29m1", 64'd536870911);
        run("q0",     64'd0);
        run("q2p29",  64'd536870912);
        run("q2p63",  64'h8000_0000_0000_0000);
        for (int i = 0; i < 4; i++) run("qrand", 64'($urandom_range(2, 536870911)));

        // Re-start while busy is ignored; q changes after acceptance have no effect.
        launch(64'd13);
        while (cyc < 19) step();
        start = 1'b1;
        q     = 64'd7;
        step();
        start = 1'b0;
        wait_done("restart", 1'b0);
        // Hold start through DONE: next cycle IDLE, then accepted.
        start = 1'b1;
        q     = 64'd7;
        push_exp(64'd7);
        step();
        chk("held_idle_ready", {63'd0, ready}, 64'd1);
        chk("held_idle_done",  {63'd0, done},  64'd0);
        step();
        cyc   = 1;
        start = 1'b0;
        q     = 64'd11;
        chk("held_launched", {63'd0, ready}, 64'd0);
        wait_done("held_q7", 1'b1);

        // Reset in cycle 30 of a q=13 run.
        launch(64'd13);
        while (cyc < 30) step();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_ready", {63'd0, ready}, 64'd1);
        chk("midrst_done",  {63'd0, done},  64'd0);
        chk("midrst_err",   {63'd0, err},   64'd0);
        chk("midrst_mu",    {33'd0, mu},    64'd0);
        chk("midrst_k",     {56'd0, k},     64'd0);
        for (int i = 0; i < 70; i++) begin
            step();
            if (i == 2) rst_n = 1'b1;
            if (done) chk("midrst_no_done", {63'd0, done}, 64'd0);
        end
        chk("midrst_idle", {63'd0, ready}, 64'd1);
        run("q5_after_rst", 64'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
